maxpool_mul_arbiter: RTL and testbench
======================================

# maxpool_mul_arbiter

Shares one unsigned 32x31 multiplier with a single registered product stage among `NUM_REQ` requesters inside the maxpool engine. Each requester is typically an address or index generator that needs a 63-bit product. Requests are granted round-robin through valid/ready handshakes. Each accepted operand pair passes through the product register, and the result is returned with the requester index and a caller tag. The block replaces per-requester multipliers and sits between the maxpool address generators and the buffer/AXI address logic.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `A_WIDTH`, 32: operand A width (unsigned).
- `B_WIDTH`, 31: operand B width (unsigned).
- `P_WIDTH`, 63: product width; must equal `A_WIDTH+B_WIDTH`.
- `TAG_WIDTH`, 8: opaque tag carried with each request.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of `res_id`.

Ports:
- `clk`  in  1  clock. One clock domain; all logic on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; combinational.
- `req_a`  in  `NUM_REQ*A_WIDTH`  packed operand A; requester i uses slice i.
- `req_b`  in  `NUM_REQ*B_WIDTH`  packed operand B.
- `req_tag`  in  `NUM_REQ*TAG_WIDTH`  packed tags.
- `res_valid`  out  1  result valid (registered).
- `res_ready`  in  1  consumer accept.
- `res_p`  out  `P_WIDTH`  product.
- `res_id`  out  `ID_WIDTH`  index of the requester that produced the result.
- `res_tag`  out  `TAG_WIDTH`  tag of that request.
- `busy`  out  1  high when `res_valid` is high or any `req_valid` is high.

## Operation
- Transfers:
  - Request transfer on requester i: `req_valid[i] && req_ready[i]` at a rising edge.
  - Result transfer: `res_valid && res_ready`.
- `advance = !res_valid || res_ready`. This acts as the multiplier clock enable.
- Grant logic:
  - The arbiter picks one winner among the asserted `req_valid` bits.
  - `req_ready[i] = grant[i] && advance`. At most one bit of `req_ready` is high.
  - No grant is issued when no request is valid.
- Round-robin:
  - The search starts at `(last+1) mod NUM_REQ` and wraps.
  - `last` updates to the winner only on a request transfer. A stalled grant does not move the pointer.
- Pipeline behaviour on `advance`:
  - If a request transfer occurs, the output register loads `{a*b, id, tag}` and `res_valid` becomes 1.
  - Otherwise `res_valid` becomes 0.
- Output holds when stalled: while `res_valid && !res_ready`, `res_p`, `res_id` and `res_tag` stay stable.
- Arithmetic:
  - Both operands are zero-extended, and the full `P_WIDTH` product is kept with no truncation.
  - Example: a = 0xFFFF_FFFF, b = 0x7FFF_FFFF gives 0x7FFF_FFFE_8000_0001.
- Requester obligations: a requester keeps `req_valid` and its operands stable until accepted. The arbiter may move its grant among requesters while `advance` is low.
- Reset values:
  - `res_valid` = 0, `res_p` = 0, `res_id` = 0, `res_tag` = 0.
  - `last` = `NUM_REQ-1`, so requester 0 wins first.
  - `busy` follows its inputs.
- Reset mid-operation: any in-flight result is discarded without handshake, and `req_ready` is forced to 0 during reset.

## Timing
- Latency: a request accepted at edge k gives `res_valid` = 1 after edge k, with the result visible in cycle k+1.
- Throughput: one product per cycle while `res_ready` is held high.
- A simultaneous result transfer and new request transfer in the same cycle is a legal back-to-back transfer with no bubble.
- `res_ready` low stalls the whole block: no requests are accepted, the pointer is frozen and the product register is not clocked.
- Combinational paths: `res_ready` → `req_ready`, and `req_valid` → `req_ready`. There are no combinational paths to `res_*`.

## Configuration
- `MAXPOOL_MUL_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest asserted index always wins.
  - The `last` pointer is removed, and a higher index can starve.
- `MAXPOOL_MUL_ARB_FIXED_PRIO_EN` undefined: round-robin as above. This is the default.

## Structure
- Shared package `maxpool_mul_arb_pkg`:
  - Default width constants (32/31/63/8).
  - A `grant_t` helper function computing a one-hot round-robin mask from `(valid, last)`.
- Sub-module `maxpool_mul_arb_rr`:
  - Combinational rotate/priority-encode picker.
  - Ports: `valid`, `last` → `grant` one-hot and `grant_idx`.
  - The top level holds the pointer, the product register and the handshakes.

## Test plan
- **Reset behaviour**: assert `reset` 2 cycles with all `req_valid` = 1 → `req_ready` = 0 and `res_valid` = 0 throughout; after release, requester 0 is granted first.
- **Single requester**: `req_valid` = 0b0010, a = 3, b = 5, tag = 0x11 → next cycle `res_valid` = 1, `res_p` = 15, `res_id` = 1, `res_tag` = 0x11.
- **Round-robin fairness**: all 4 valid continuously, `res_ready` = 1 → `res_id` sequence is 0,1,2,3,0,1,… with one result per cycle.
- **Backpressure**: hold `res_ready` = 0 for 5 cycles with the result at p = 42 → `res_p` stays 42, `req_ready` = 0 and the grant pointer is unchanged; on release, the next requester in order is accepted with no result lost or duplicated.
- **Width corner**: a = 0xFFFF_FFFF, b = 0x7FFF_FFFF → `res_p` = 0x7FFF_FFFE_8000_0001.
- **Reset mid-stall**: reset while `res_valid` = 1 and `res_ready` = 0 → `res_valid` = 0 after the edge; the first grant after reset goes to requester 0. With `MAXPOOL_MUL_ARB_FIXED_PRIO_EN` defined, all valid gives `res_id` = 0 every cycle.

Source files
------------

// File: rtl/maxpool_mul_arb_pkg.sv
// maxpool_mul_arb_pkg: shared widths and round-robin grant helper for the maxpool multiplier arbiter
package maxpool_mul_arb_pkg;
  localparam int DEF_A_WIDTH = 32;
  localparam int DEF_B_WIDTH = 31;
  localparam int DEF_P_WIDTH = 63;
  localparam int DEF_TAG_WIDTH = 8;
  localparam int MAX_REQ = 8;
  function automatic logic [MAX_REQ-1:0] grant_t(input logic [MAX_REQ-1:0] valid, input int unsigned last, input int unsigned n);
    logic [2:0] idx;
    grant_t = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((last + k) % n);
      if (k <= n && grant_t == '0 && valid[idx]) grant_t[idx] = 1'b1;
    end
  endfunction
endpackage

// File: rtl/maxpool_mul_arb_rr.sv
// maxpool_mul_arb_rr: combinational round-robin picker, search starts just after last
module maxpool_mul_arb_rr
  import maxpool_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [ID_WIDTH-1:0] last,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);
  logic [MAX_REQ-1:0] g;
  always_comb begin
    g = grant_t(MAX_REQ'(valid), 32'(last), 32'(NUM_REQ));
    grant = g[NUM_REQ-1:0];
    grant_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) if (g[i]) grant_idx = ID_WIDTH'(i);
  end
endmodule

// File: rtl/maxpool_mul_arbiter.sv
// maxpool_mul_arbiter: shares one registered multiplier among requesters with valid/ready handshakes
// MAXPOOL_MUL_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module maxpool_mul_arbiter
  import maxpool_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int P_WIDTH = DEF_P_WIDTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]     req_b,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [P_WIDTH-1:0]             res_p,
  output logic [ID_WIDTH-1:0]            res_id,
  output logic [TAG_WIDTH-1:0]           res_tag,
  output logic                           busy
);
  logic adv, fire;
  logic [NUM_REQ-1:0] grant;
  logic [ID_WIDTH-1:0] grant_idx, rr_base;
  logic [A_WIDTH-1:0] a_sel;
  logic [B_WIDTH-1:0] b_sel;
  logic res_valid_q, res_valid_d;
  logic [P_WIDTH-1:0] res_p_q, res_p_d;
  logic [ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [TAG_WIDTH-1:0] res_tag_q, res_tag_d;
`ifdef MAXPOOL_MUL_ARB_FIXED_PRIO_EN
  // Searching from NUM_REQ-1 onward always starts at index 0.
  assign rr_base = ID_WIDTH'(NUM_REQ - 1);
`else
  logic [ID_WIDTH-1:0] last_q, last_d;
  assign rr_base = last_q;
  assign last_d = fire ? grant_idx : last_q;
  always_ff @(posedge clk) last_q <= reset ? ID_WIDTH'(NUM_REQ - 1) : last_d;
`endif
  maxpool_mul_arb_rr #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
    .valid(req_valid),
    .last(rr_base),
    .grant(grant),
    .grant_idx(grant_idx)
  );
  always_comb begin
    adv = !res_valid_q || res_ready;
    req_ready = reset ? '0 : grant & {NUM_REQ{adv}};
    fire = |req_ready;
    a_sel = req_a[grant_idx*A_WIDTH +: A_WIDTH];
    b_sel = req_b[grant_idx*B_WIDTH +: B_WIDTH];
    res_valid_d = adv ? fire : res_valid_q;
    res_p_d = fire ? P_WIDTH'(a_sel) * P_WIDTH'(b_sel) : res_p_q;
    res_id_d = fire ? grant_idx : res_id_q;
    res_tag_d = fire ? req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH] : res_tag_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_p_q <= '0;
      res_id_q <= '0;
      res_tag_q <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_p_q <= res_p_d;
      res_id_q <= res_id_d;
      res_tag_q <= res_tag_d;
    end
  end
  assign res_valid = res_valid_q;
  assign res_p = res_p_q;
  assign res_id = res_id_q;
  assign res_tag = res_tag_q;
  assign busy = res_valid_q || (|req_valid);
endmodule

// File: tb/tb_maxpool_mul_arbiter.sv
// tb_maxpool_mul_arbiter: directed and random checks of the shared multiplier arbiter against a reference model
module tb_maxpool_mul_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset, res_ready, res_valid, busy;
  logic [N-1:0] req_valid, req_ready, rv, acc;
  logic [N*32-1:0] req_a;
  logic [N*31-1:0] req_b;
  logic [N*8-1:0] req_tag;
  logic [62:0] res_p;
  logic [1:0] res_id;
  logic [7:0] res_tag;
  logic [31:0] ra[N];
  logic [30:0] rb[N];
  logic [7:0] rt[N];
  int nvec = 0, nmiss = 0;
  logic m_valid = 1'b0;
  logic [62:0] m_p = '0;
  int m_id = 0, m_last = N - 1, prev_id;
  logic [7:0] m_tag = '0;
  always #5 clk = ~clk;
  assign req_valid = rv;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[g*32 +: 32] = ra[g];
    assign req_b[g*31 +: 31] = rb[g];
    assign req_tag[g*8 +: 8] = rt[g];
  end
  maxpool_mul_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .res_valid(res_valid),
    .res_ready(res_ready), .res_p(res_p), .res_id(res_id), .res_tag(res_tag), .busy(busy)
  );
  task automatic check(input string nm, input logic [63:0] o, input logic [63:0] e);
    nvec++;
    assert (o === e) else begin
      nmiss++;
      $error("FAIL %s: got %h, want %h", nm, o, e);
    end
  endtask
  function automatic int winner();
    int s;
`ifdef MAXPOOL_MUL_ARB_FIXED_PRIO_EN
    s = N - 1;
`else
    s = m_last;
`endif
    for (int k = 1; k <= N; k++) if (rv[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction
  task automatic tick(output logic [N-1:0] accepted);
    int w;
    logic adv;
    logic [N-1:0] er;
    #1;
    adv = !m_valid || res_ready;
    w = winner();
    er = (!reset && adv && w >= 0) ? N'(1 << w) : '0;
    check("req_ready", 64'(req_ready), 64'(er));
    check("busy", 64'(busy), 64'(m_valid || (|rv)));
    @(posedge clk);
    accepted = er;
    if (reset) begin
      m_valid = 0; m_p = '0; m_id = 0; m_tag = '0; m_last = N - 1;
    end else if (adv) begin
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_p = 63'(64'(ra[w]) * 64'(rb[w]));
        m_id = w;
        m_tag = rt[w];
        m_last = w;
      end
    end
    #1;
    check("res_valid", 64'(res_valid), 64'(m_valid));
    check("res_p", 64'(res_p), 64'(m_p));
    check("res_id", 64'(res_id), 64'(m_id));
    check("res_tag", 64'(res_tag), 64'(m_tag));
  endtask
  task automatic drain();
    for (int k = 0; k < 20 && (rv != 0 || m_valid); k++) begin
      tick(acc);
      rv &= ~acc;
    end
    check("drained", 64'(res_valid), 64'(0));
  endtask
  function automatic logic [31:0] pick32();
    int s = int'($urandom % 4);
    return s == 0 ? 32'hFFFF_FFFF : s == 1 ? 32'h0 : 32'($urandom);
  endfunction
  initial begin
    for (int i = 0; i < N; i++) begin
      ra[i] = 32'(i + 1); rb[i] = 31'(i + 2); rt[i] = 8'(8'h40 + i);
    end
    reset = 1; rv = '1; res_ready = 1;
    tick(acc);
    check("rst_ready0", 64'(req_ready), 64'(0));
    tick(acc);
    check("rst_valid", 64'(res_valid), 64'(0));
    reset = 0;
    tick(acc);
    check("first_grant", 64'(res_id), 64'(0));
    rv = '0;
    drain();
    rv = 4'b0010; ra[1] = 3; rb[1] = 5; rt[1] = 8'h11;
    tick(acc);
    rv = '0;
    check("single_v", 64'(res_valid), 64'(1));
    check("single_p", 64'(res_p), 64'd15);
    check("single_id", 64'(res_id), 64'd1);
    check("single_tag", 64'(res_tag), 64'h11);
    drain();
    rv = 4'b1111;
    tick(acc);
    prev_id = int'(res_id);
    for (int k = 0; k < 8; k++) begin
      tick(acc);
      check("fair_valid", 64'(res_valid), 64'(1));
`ifdef MAXPOOL_MUL_ARB_FIXED_PRIO_EN
      check("fixed_id", 64'(res_id), 64'(0));
`else
      check("rr_order", 64'(res_id), 64'((prev_id + 1) % N));
`endif
      prev_id = int'(res_id);
    end
    rv = '0;
    drain();
    rv = 4'b0001; ra[0] = 6; rb[0] = 7;
    tick(acc);
    rv = 4'b1110; res_ready = 0;
    for (int k = 0; k < 5; k++) begin
      tick(acc);
      check("stall_p", 64'(res_p), 64'd42);
      check("stall_ready", 64'(req_ready), 64'(0));
    end
    res_ready = 1;
    tick(acc);
    check("release_id", 64'(res_id), 64'd1);
    rv &= ~acc;
    drain();
    rv = 4'b0100; ra[2] = 32'hFFFF_FFFF; rb[2] = 31'h7FFF_FFFF;
    tick(acc);
    rv = '0;
    check("width_corner", 64'(res_p), 64'h7FFF_FFFE_8000_0001);
    drain();
    rv = 4'b0100; ra[2] = 9;
    tick(acc);
    rv = '0; res_ready = 0;
    tick(acc);
    reset = 1; rv = '1;
    tick(acc);
    check("midrst_valid", 64'(res_valid), 64'(0));
    reset = 0; res_ready = 1;
    tick(acc);
    check("midrst_first", 64'(res_id), 64'(0));
    rv = '0;
    drain();
    for (int c = 0; c < 400; c++) begin
      res_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) if (acc[i] || !rv[i]) begin
        rv[i] = 1'($urandom % 2);
        ra[i] = pick32(); rb[i] = 31'(pick32()); rt[i] = 8'($urandom);
      end
      tick(acc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
